cas_collector: RTL

CAS_COLLECTOR -- requirements
Module: cas_collector

---
 rtl/cas_pkg.sv | 21 ++
 rtl/dual_push_fifo.sv | 52 +++++
 rtl/cas_collector.sv | 69 ++++++
 3 files changed

// File: rtl/cas_pkg.sv
// Shared definitions for the compare-and-swap datapath and its output collector.
package cas_pkg;

  localparam int unsigned ADDRW_DEF = 10;
  localparam int unsigned WL_DEF    = 32;

  // One index/value entry as carried between the CAS stage and the collector.
  typedef struct packed {
    logic [ADDRW_DEF-1:0] index;
    logic [WL_DEF-1:0]    value;
  } cas_entry_t;

  function automatic cas_entry_t make_entry(input logic [ADDRW_DEF-1:0] index,
                                            input logic [WL_DEF-1:0]    value);
    cas_entry_t e;
    e.index = index;
    e.value = value;
    return e;
  endfunction

endpackage

// File: rtl/dual_push_fifo.sv
// Circular buffer accepting up to two writes and one read per clock.
module dual_push_fifo #(
  parameter  int unsigned W     = 42,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    push_cnt,
  input  logic [W-1:0]  wr_data0,
  input  logic [W-1:0]  wr_data1,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_nxt;

  // Second write slot; wraps naturally from DEPTH-1 to 0.
  always_comb begin
    wp_nxt = wp + 1'b1;
  end

  // Storage writes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wp]     <= wr_data0;
    if (push_cnt == 2'd2) mem[wp_nxt] <= wr_data1;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + PW'(push_cnt);
      rp    <= rp + PW'(pop);
      level <= level + LW'(push_cnt) - LW'(pop);
    end
  end

  // First-word-fall-through head.
  always_comb begin
    rd_data = mem[rp];
  end

endmodule

// File: rtl/cas_collector.sv
// Collects paired entries from the CAS pipeline into an ordered output stream.
module cas_collector
  import cas_pkg::*;
#(
  parameter  int unsigned ADDRW = ADDRW_DEF,
  parameter  int unsigned WL    = WL_DEF,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_ena,
  output logic             cas_ena,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic [ADDRW-1:0] in_index1,
  input  logic [ADDRW-1:0] in_index2,
  input  logic [WL-1:0]    in_value1,
  input  logic [WL-1:0]    in_value2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDRW-1:0] out_index,
  output logic [WL-1:0]    out_value,
  output logic [LW-1:0]    level
);

  localparam int unsigned W = ADDRW + WL;

  logic [1:0]   push_cnt;
  logic [W-1:0] wr_data0;
  logic [W-1:0] wr_data1;
  logic [W-1:0] rd_data;
  logic         pop;

  // Admit only with room for a full pair, judged on registered level alone.
  always_comb begin
    cas_ena = up_ena && (level <= LW'(DEPTH - 2));
  end

  // Compact valid entries so a lone entry 2 lands in the first write slot.
  always_comb begin
    push_cnt = '0;
    wr_data0 = in_valid1 ? {in_index1, in_value1} : {in_index2, in_value2};
    wr_data1 = {in_index2, in_value2};
    if (cas_ena) push_cnt = {1'b0, in_valid1} + {1'b0, in_valid2};
  end

  // Output stream handshake.
  always_comb begin
    out_valid              = (level != '0);
    pop                    = out_valid && out_ready;
    {out_index, out_value} = rd_data;
  end

  dual_push_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_cnt (push_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .pop      (pop),
    .rd_data  (rd_data),
    .level    (level)
  );

endmodule
